// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq
// Scan sequencer for a 3-to-8 decoder. It steps the select code In through
// 0..7 and holds each code with E=1 for DWELL cycles. Optionally it blanks the
// decoder (E=0) for GAP cycles while In changes. It supports a single sweep
// (ending with a one-cycle done pulse) and a continuous scan (7 wraps to 0).
//
// Ports:
//   clka  - clock; all state changes on the rising edge
//   rst   - asynchronous active-high reset
//   start - one-cycle scan request; ignored unless idle
//   stop  - abort; returns to idle at the next edge (wins over start)
//   cont  - 1 = continuous, 0 = single sweep; latched with an accepted start
//   E     - registered decoder enable
//   In    - registered decoder select code
//   busy  - high from accepted start until the sweep ends or is aborted
//   done  - one-cycle pulse when a single sweep completes normally
module decoder_scan_seq #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic       clka,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  output logic       E,
  output logic [2:0] In,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK, DONE} state_t;

  // Terminal counts. The counter runs 0..N-1, and the state advances on the edge
  // where it equals N-1. This gives exactly N cycles per phase.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit               HAS_GAP    = (GAP > 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cont_lat;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cont_lat <= 1'b0;
      E        <= 1'b0;
      In       <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !stop) begin
            state    <= DRIVE;
            cnt      <= '0;
            cont_lat <= cont;
            E        <= 1'b1;
            In       <= 3'd0;
            busy     <= 1'b1;
          end
        end

        DRIVE: begin
          if (stop) begin
            state <= IDLE;
            cnt   <= '0;
            E     <= 1'b0;
            In    <= 3'd0;
            busy  <= 1'b0;
          end else if (cnt == DWELL_LAST) begin
            cnt <= '0;
            if (In != 3'd7 || cont_lat) begin
              // The 3-bit add wraps 7 -> 0 in continuous mode.
              In <= In + 3'd1;
              if (HAS_GAP) begin
                state <= BLANK;
                E     <= 1'b0;
              end
            end else begin
              state <= DONE;
              E     <= 1'b0;
              In    <= 3'd0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        BLANK: begin
          if (stop) begin
            state <= IDLE;
            cnt   <= '0;
            In    <= 3'd0;
            busy  <= 1'b0;
          end else if (cnt == GAP_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
            E     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          // The done pulse lasts one cycle. A stop here ends in the same place.
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          E     <= 1'b0;
          In    <= 3'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/decoder_scan_seq.md
Name: decoder_scan_seq

Overview:
Scan sequencer that drives the 3-to-8 decoder's enable (E) and select (In) inputs. It steps In through 0..7, holds each code for a programmable dwell time, and inserts optional blanking (E=0) while In changes so decoder outputs never glitch between codes. Supports single-sweep and continuous modes, with start/stop control and a done pulse. Sits directly upstream of the decoder; its E and In outputs connect one-to-one to decoder E and In.

Parameters:
DWELL, 4, cycles E=1 per code; legal range 1..65535.
GAP, 1, blanking cycles (E=0) between consecutive codes; legal range 0..65535. 0 means no blanking.
CNT_W, 16, dwell/gap counter width; must hold max(DWELL, GAP).

Ports:
clka  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a scan; ignored while busy=1
stop  input  1  abort request; takes effect at the next edge
cont  input  1  1 = continuous scan (7 wraps to 0), 0 = single sweep; sampled only with an accepted start
E  output  1  registered decoder enable
In  output  3  registered decoder select code
busy  output  1  high from accepted start until the sweep ends or is aborted
done  output  1  one-cycle pulse when a single sweep completes normally

Behaviour:
- Reset (async, any time, including mid-scan): state=IDLE, E=0, In=3'b000, busy=0, done=0, counter=0, latched mode=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, DRIVE, BLANK, DONE.
- IDLE: E=0, In holds 0, busy=0. If start=1 and stop=0 at edge k, then from edge k: state=DRIVE, E=1, In=0, busy=1, counter=0, and cont is latched.
- DRIVE: E=1 and In stays stable. The counter increments each cycle. After DWELL cycles with E=1 (edge k+DWELL for code 0):
  - If In != 7 and GAP > 0: go to BLANK; E=0 and In=In+1 on the same edge.
  - If In != 7 and GAP == 0: stay in DRIVE; In=In+1 and E stays 1.
  - If In == 7 and latched cont=1: advance exactly as above, but In wraps to 0 (modulo 8).
  - If In == 7 and latched cont=0: go to DONE.
- BLANK: E=0 and In holds the new code. After GAP cycles: go to DRIVE with E=1 and counter=0.
- DONE: lasts exactly one cycle, with done=1, E=0, In=0, busy=0. Then go to IDLE.
- Single-sweep timing: code n first drives E=1 at edge k + n*(DWELL+GAP). The done cycle starts at edge k + 8*DWELL + 7*GAP.
- stop=1 in DRIVE, BLANK or DONE: at the next edge go to IDLE with E=0, In=0, busy=0, done=0. No done pulse is generated.
- start and stop asserted together in IDLE: stop wins and the scan does not start.
- start while busy=1 or in DONE: ignored. It is not queued.
- cont changes mid-scan: no effect; only the value latched at start is used.
- The counter never exceeds max(DWELL, GAP)-1. Its compare is exact equality with no off-by-one slack.

Test Plan:
- Reset: assert rst asynchronously mid-DRIVE with In=3 -> E=0, In=0, busy=0 immediately, before the next clock edge; release, then idle with no activity.
- Single sweep, DWELL=4, GAP=1: start at edge 0 -> E=1 pattern 4 on / 1 off. In=0,1,...,7 where code n has E=1 starting at edge 5n. done=1 only in cycle 39, busy=1 over edges 0..38. Each decoder Out shows one-hot 8'h01..8'h80 in order, Out=0 during every gap.
- Continuous, DWELL=2, GAP=0: start with cont=1 -> In goes 0..7,0,1,... changing every 2 cycles, E stays 1 throughout the wrap 7->0, done is never asserted; stop at edge 20 -> E=0, In=0, busy=0 at edge 21.
- Abort: single sweep, stop during the BLANK between codes 2 and 3 -> IDLE at the next edge, done stays 0. A new start afterwards restarts cleanly from In=0.
- Contention: start and stop together in IDLE -> remains idle, busy=0. Start pulsed at edge 10 of a running sweep -> no effect on the In/E sequence or the done timing.
- Boundary, DWELL=1, GAP=0, single: start at edge 0 -> In changes every cycle 0..7 with E=1 for 8 consecutive cycles, done=1 in cycle 8.
